// File: rtl/mem_bus_arbiter_if.sv
// Shared data-memory port bundle: three requester slots in, one muxed memory port and grant/stall out.
interface mem_bus_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  logic [2:0]    req;
  logic [2:0]    lock;
  logic [AW-1:0] addr0;
  logic [AW-1:0] addr1;
  logic [AW-1:0] addr2;
  logic          we0;
  logic          we1;
  logic          we2;
  logic [DW-1:0] wdata0;
  logic [DW-1:0] wdata1;
  logic [DW-1:0] wdata2;
  logic [2:0]    gnt;
  logic [2:0]    stall;
  logic [AW-1:0] mem_addr;
  logic          mem_write;
  logic [DW-1:0] mem_wdata;
  logic [1:0]    owner;

  modport master (
    output req, lock, addr0, addr1, addr2, we0, we1, we2, wdata0, wdata1, wdata2,
    input  gnt, stall, mem_addr, mem_write, mem_wdata, owner
  );

  modport slave (
    input  req, lock, addr0, addr1, addr2, we0, we1, we2, wdata0, wdata1, wdata2,
    output gnt, stall, mem_addr, mem_write, mem_wdata, owner
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Round-robin 3-port memory arbiter with bounded burst lock; grant registered 1 cycle after req.
// No backpressure on the memory side; losing requesters see a combinational per-port stall.
module mem_bus_arbiter #(
  parameter int AW        = 16,
  parameter int DW        = 16,
  parameter int MAX_BURST = 16
) (
  input  logic             clk,
  input  logic             rst,
  mem_bus_arbiter_if.slave bus
);
  typedef enum logic {IDLE, OWNED} state_t;

  localparam logic [7:0] HOLD_MAX = 8'(MAX_BURST - 1);

  state_t        state_q, state_d;
  logic [2:0]    gnt_q, gnt_d;
  logic [1:0]    last_q, last_d;
  logic [7:0]    hold_cnt_q, hold_cnt_d;
  logic [1:0]    own_idx;
  logic [2:0]    others;
  logic [2:0]    owner_req;
  logic [2:0]    owner_lock;
  logic [1:0]    rr_from_last;
  logic [1:0]    rr_from_owner;
  logic          grant_new;
  logic [1:0]    grant_idx;
  logic [AW-1:0] addr_sel;
  logic [DW-1:0] wdata_sel;

  // Returns the first requesting port after 'from', wrapping 2->0; 3 if none.
  function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] from);
    logic [1:0] idx;
    rr_pick = 2'd3;
    idx     = from;
    for (int k = 0; k < 3; k++) begin
      idx = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
      if (rr_pick == 2'd3 && r[idx]) rr_pick = idx;
    end
  endfunction

  function automatic logic [2:0] onehot(input logic [1:0] idx);
    case (idx)
      2'd0:    onehot = 3'b001;
      2'd1:    onehot = 3'b010;
      2'd2:    onehot = 3'b100;
      default: onehot = 3'b000;
    endcase
  endfunction

  always_comb begin
    case (gnt_q)
      3'b001:  own_idx = 2'd0;
      3'b010:  own_idx = 2'd1;
      3'b100:  own_idx = 2'd2;
      default: own_idx = 2'd3;
    endcase
  end

  assign others        = bus.req & ~gnt_q;
  assign owner_req     = bus.req & gnt_q;
  assign owner_lock    = bus.lock & gnt_q;
  assign rr_from_last  = rr_pick(bus.req, last_q);
  assign rr_from_owner = rr_pick(bus.req, own_idx);

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    last_d     = last_q;
    hold_cnt_d = hold_cnt_q;
    grant_new  = 1'b0;
    grant_idx  = rr_from_last;
    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          grant_new = 1'b1;
          grant_idx = rr_from_last;
        end
      end
      OWNED: begin
        if (!(|owner_req)) begin
          if (|others) begin
            grant_new = 1'b1;
            grant_idx = rr_from_owner;
          end else begin
            state_d    = IDLE;
            gnt_d      = 3'b000;
            hold_cnt_d = 8'd0;
          end
        end else if (|others) begin
          // Owner still requesting but contended: unlocked yields now, locked yields at the burst bound.
          if (!(|owner_lock) || hold_cnt_q >= HOLD_MAX) begin
            grant_new = 1'b1;
            grant_idx = rr_from_owner;
          end else begin
            hold_cnt_d = hold_cnt_q + 8'd1;
          end
        end
      end
      default: ;
    endcase
    if (grant_new) begin
      state_d    = OWNED;
      gnt_d      = onehot(grant_idx);
      last_d     = grant_idx;
      hold_cnt_d = 8'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      gnt_q      <= 3'b000;
      last_q     <= 2'd2;
      hold_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      last_q     <= last_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  always_comb begin
    addr_sel  = '0;
    wdata_sel = '0;
    case (gnt_q)
      3'b001: begin addr_sel = bus.addr0; wdata_sel = bus.wdata0; end
      3'b010: begin addr_sel = bus.addr1; wdata_sel = bus.wdata1; end
      3'b100: begin addr_sel = bus.addr2; wdata_sel = bus.wdata2; end
      default: ;
    endcase
  end

  assign bus.gnt       = gnt_q;
  assign bus.stall     = bus.req & ~gnt_q;
  assign bus.owner     = own_idx;
  assign bus.mem_addr  = addr_sel;
  assign bus.mem_wdata = wdata_sel;
  // A granted port that has dropped req must not write.
  assign bus.mem_write = |(gnt_q & bus.req & {bus.we2, bus.we1, bus.we0});
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios plus random traffic against a behavioural model.
module tb_mem_bus_arbiter;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int MAX_BURST = 4;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  // Model: current owner (-1 when idle), last owner, locked contended edges spent in this tenure.
  int m_owner;
  int m_last;
  int m_used;

  mem_bus_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  mem_bus_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MAX_BURST)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int rr(input logic [2:0] r, input int from);
    for (int k = 1; k <= 3; k++) begin
      int p;
      p = (from + k) % 3;
      if (r[p]) return p;
    end
    return -1;
  endfunction

  task automatic model_step();
    logic [2:0] r;
    logic [2:0] oth;
    logic [2:0] one;
    one = 3'b001;
    r   = bus.req;
    if (rst) begin
      m_owner = -1;
      m_last  = 2;
      m_used  = 0;
    end else if (m_owner < 0) begin
      if (r != 3'b000) begin
        m_owner = rr(r, m_last);
        m_last  = m_owner;
        m_used  = 0;
      end
    end else begin
      oth = r & ~(one << m_owner);
      if (!r[m_owner]) begin
        if (oth != 3'b000) begin
          m_owner = rr(oth, m_owner);
          m_last  = m_owner;
        end else begin
          m_owner = -1;
        end
        m_used = 0;
      end else if (oth != 3'b000) begin
        if (bus.lock[m_owner]) m_used++;
        if (!bus.lock[m_owner] || m_used >= MAX_BURST) begin
          m_owner = rr(oth, m_owner);
          m_last  = m_owner;
          m_used  = 0;
        end
      end
    end
  endtask

  task automatic check_all();
    logic [2:0]    eg;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    logic          ew;
    eg = 3'b000;
    ea = '0;
    ed = '0;
    ew = 1'b0;
    if (m_owner >= 0) eg[m_owner] = 1'b1;
    case (m_owner)
      0: begin ea = bus.addr0; ed = bus.wdata0; ew = bus.req[0] & bus.we0; end
      1: begin ea = bus.addr1; ed = bus.wdata1; ew = bus.req[1] & bus.we1; end
      2: begin ea = bus.addr2; ed = bus.wdata2; ew = bus.req[2] & bus.we2; end
      default: ;
    endcase
    chk("gnt", 32'(bus.gnt), 32'(eg));
    chk("owner", 32'(bus.owner), (m_owner < 0) ? 32'd3 : 32'(m_owner));
    chk("stall", 32'(bus.stall), 32'(bus.req & ~eg));
    chk("mem_addr", 32'(bus.mem_addr), 32'(ea));
    chk("mem_wdata", 32'(bus.mem_wdata), 32'(ed));
    chk("mem_write", 32'(bus.mem_write), 32'(ew));
  endtask

  // Inputs are set by the caller just after an edge; check, then advance one edge.
  task automatic cycle();
    #1;
    check_all();
    @(posedge clk);
    model_step();
    #1;
  endtask

  initial begin
    logic [2:0] rr_seq [6];
    rr_seq = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};

    rst        = 1'b1;
    bus.req    = 3'b111;
    bus.lock   = 3'b000;
    bus.addr0  = 16'h0A00;
    bus.addr1  = 16'h0B00;
    bus.addr2  = 16'h0C00;
    bus.we0    = 1'b1;
    bus.we1    = 1'b0;
    bus.we2    = 1'b1;
    bus.wdata0 = 16'h1111;
    bus.wdata1 = 16'h2222;
    bus.wdata2 = 16'h3333;
    m_owner    = -1;
    m_last     = 2;
    m_used     = 0;
    @(posedge clk);
    model_step();
    #1;

    // Reset held with all ports requesting
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("rst_gnt", 32'(bus.gnt), 32'd0);
      chk("rst_write", 32'(bus.mem_write), 32'd0);
      chk("rst_owner", 32'(bus.owner), 32'd3);
      chk("rst_stall", 32'(bus.stall), 32'(3'b111));
      cycle();
    end
    rst = 1'b0;
    cycle();
    chk("post_rst_gnt", 32'(bus.gnt), 32'(3'b001));

    // Unlocked round robin
    for (int i = 0; i < 6; i++) begin
      chk("rr_seq", 32'(bus.gnt), 32'(rr_seq[i]));
      cycle();
    end
    bus.req = 3'b000;
    cycle();
    cycle();
    chk("idle_gnt", 32'(bus.gnt), 32'd0);

    // Burst bound: port 1 locked, port 0 joins after 3 cycles
    bus.req   = 3'b010;
    bus.lock  = 3'b010;
    bus.we1   = 1'b1;
    bus.addr1 = 16'h0200;
    for (int i = 0; i < 3; i++) cycle();
    bus.req = 3'b011;
    for (int i = 0; i < MAX_BURST; i++) begin
      #1;
      chk("burst_hold", 32'(bus.gnt), 32'(3'b010));
      chk("burst_addr", 32'(bus.mem_addr), 32'h0200);
      cycle();
    end
    chk("burst_handoff", 32'(bus.gnt), 32'(3'b001));
    chk("burst_addr0", 32'(bus.mem_addr), 32'(bus.addr0));
    bus.req  = 3'b000;
    bus.lock = 3'b000;
    cycle();
    cycle();

    // Write masking after port 2 drops req
    bus.req    = 3'b100;
    bus.we2    = 1'b1;
    bus.wdata2 = 16'hBEEF;
    cycle();
    chk("mask_gnt", 32'(bus.gnt), 32'(3'b100));
    chk("mask_wr_on", 32'(bus.mem_write), 32'd1);
    chk("mask_wdata", 32'(bus.mem_wdata), 32'hBEEF);
    bus.req = 3'b000;
    #1;
    chk("mask_wr_off", 32'(bus.mem_write), 32'd0);
    cycle();
    chk("mask_release", 32'(bus.gnt), 32'd0);

    // Gapless handoff 0 -> 2
    bus.req = 3'b001;
    cycle();
    chk("ho_own0", 32'(bus.gnt), 32'(3'b001));
    bus.req = 3'b100;
    cycle();
    chk("ho_gnt2", 32'(bus.gnt), 32'(3'b100));
    bus.req = 3'b000;
    cycle();

    // Reset in the middle of a locked burst
    bus.req    = 3'b010;
    bus.lock   = 3'b010;
    bus.we1    = 1'b1;
    bus.addr1  = 16'h0040;
    bus.wdata1 = 16'h1234;
    cycle();
    cycle();
    chk("mid_wr", 32'(bus.mem_write), 32'd1);
    chk("mid_addr", 32'(bus.mem_addr), 32'h0040);
    rst = 1'b1;
    cycle();
    chk("mid_rst_gnt", 32'(bus.gnt), 32'd0);
    chk("mid_rst_wr", 32'(bus.mem_write), 32'd0);
    rst = 1'b0;
    cycle();
    chk("mid_regain", 32'(bus.gnt), 32'(3'b010));
    bus.lock = 3'b000;

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      for (int b = 0; b < 3; b++) begin
        if ($urandom_range(0, 3) == 0) bus.req[b] = ~bus.req[b];
        if ($urandom_range(0, 4) == 0) bus.lock[b] = ~bus.lock[b];
      end
      rst        = ($urandom_range(0, 249) == 0);
      bus.addr0  = 16'($urandom);
      bus.addr1  = 16'($urandom);
      bus.addr2  = 16'($urandom);
      bus.wdata0 = 16'($urandom);
      bus.wdata1 = 16'($urandom);
      bus.wdata2 = 16'($urandom);
      bus.we0    = 1'($urandom);
      bus.we1    = 1'($urandom);
      bus.we2    = 1'($urandom);
      cycle();
    end
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
